gpu_program_loader: RTL and testbench

Host-side program loader for the SIMD GPU core. It accepts a stream of 16-bit instruction words over a valid/ready handshake and writes them into the core's instruction memory write port. It holds the core in reset while loading, releases it for a bounded run window, then signals completion. It is the writer counterpart to the core's PC-driven instruction fetch, and sits between the host bus and `simd_gpu_core`.

---
 rtl/gpu_pkg.sv | 27 ++
 rtl/gpu_program_loader.sv | 113 +++++++++++
 tb/tb_gpu_program_loader.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gpu_pkg.sv
// Types and constants shared between the program loader and the SIMD core decode.
package gpu_pkg;

   localparam int unsigned INSTR_W = 16;

   // Opcode field location inside an instruction word.
   localparam int unsigned OPC_MSB = 15;
   localparam int unsigned OPC_LSB = 12;
   localparam int unsigned OPC_W   = OPC_MSB - OPC_LSB + 1;

   localparam logic [OPC_W-1:0] OP_NOP = 4'h0;
   localparam logic [OPC_W-1:0] OP_ADD = 4'h4;
   localparam logic [OPC_W-1:0] OP_SUB = 4'h5;
   localparam logic [OPC_W-1:0] OP_LDI = 4'h6;
   localparam logic [OPC_W-1:0] OP_MUL = 4'h7;

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } loader_state_t;

   function automatic logic [OPC_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
      return instr[OPC_MSB:OPC_LSB];
   endfunction

endpackage

// File: rtl/gpu_program_loader.sv
// Streams host instruction words into the core's instruction memory, holds the
// core in reset while loading, then releases it for a bounded run window.
module gpu_program_loader #(
   parameter int unsigned IMEM_DEPTH = 8,
   parameter int unsigned INSTR_W    = gpu_pkg::INSTR_W,
   parameter int unsigned PIPE_SLACK = 2
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          host_valid,
   output logic                          host_ready,
   input  logic [INSTR_W-1:0]            host_data,
   input  logic                          host_last,
   output logic                          imem_we,
   output logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
   output logic [INSTR_W-1:0]            imem_wdata,
   output logic                          core_reset,
   output logic                          busy,
   output logic                          done,
   output logic                          trunc
);
   import gpu_pkg::*;

   localparam int unsigned AW = $clog2(IMEM_DEPTH);
   localparam int unsigned NW = AW + 1;
   localparam int unsigned RW = $clog2(IMEM_DEPTH + PIPE_SLACK + 1);

   loader_state_t state_q, state_d;
   logic [AW-1:0] wptr_q, wptr_d;
   logic [NW-1:0] nwords_q, nwords_d;
   logic [RW-1:0] run_cnt_q, run_cnt_d;
   logic          trunc_q, trunc_d;
   logic          core_reset_q;
   logic          accept;

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= LOAD;
         wptr_q       <= '0;
         nwords_q     <= '0;
         run_cnt_q    <= '0;
         trunc_q      <= 1'b0;
         core_reset_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         wptr_q       <= wptr_d;
         nwords_q     <= nwords_d;
         run_cnt_q    <= run_cnt_d;
         trunc_q      <= trunc_d;
         // Registered from the next state so the core leaves reset on the accepting edge.
         core_reset_q <= (state_d != RUN);
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d   = state_q;
      wptr_d    = wptr_q;
      nwords_d  = nwords_q;
      run_cnt_d = run_cnt_q;
      trunc_d   = trunc_q;
      accept    = host_valid && (state_q == LOAD);

      case (state_q)
         LOAD: begin
            if (accept) begin
               wptr_d   = wptr_q + AW'(1);
               nwords_d = nwords_q + NW'(1);
               if (nwords_q == '0) begin
                  trunc_d = 1'b0;
               end
               // A full memory ends the load; without host_last the tail is lost.
               if (wptr_q == AW'(IMEM_DEPTH - 1)) begin
                  state_d = RUN;
                  if (!host_last) begin
                     trunc_d = 1'b1;
                  end
               end else if (host_last) begin
                  state_d = RUN;
               end
               if (state_d == RUN) begin
                  run_cnt_d = RW'(nwords_d) + RW'(PIPE_SLACK);
               end
            end
         end
         RUN: begin
            run_cnt_d = run_cnt_q - RW'(1);
            if (run_cnt_q == RW'(1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            wptr_d   = '0;
            nwords_d = '0;
            state_d  = LOAD;
         end
         default: begin
            state_d = LOAD;
         end
      endcase
   end

   assign host_ready = (state_q == LOAD);
   assign imem_we    = accept;
   assign imem_waddr = wptr_q;
   assign imem_wdata = host_data;
   assign core_reset = core_reset_q;
   assign busy       = (state_q != LOAD);
   assign done       = (state_q == DONE);
   assign trunc      = trunc_q;

endmodule

// File: tb/tb_gpu_program_loader.sv
// Scoreboard bench for gpu_program_loader: expected writes and run windows are
// queued by the stimulus and consumed by a negedge monitor.
module tb_gpu_program_loader;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned IW    = 16;
   localparam int unsigned SLACK = 2;
   localparam int unsigned AW    = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          host_valid;
   logic          host_ready;
   logic [IW-1:0] host_data;
   logic          host_last;
   logic          imem_we;
   logic [AW-1:0] imem_waddr;
   logic [IW-1:0] imem_wdata;
   logic          core_reset;
   logic          busy;
   logic          done;
   logic          trunc;

   int n_tests = 0;
   int n_fail  = 0;

   // {addr, data} of each expected write; {run_len, trunc} of each expected done.
   logic [AW+IW-1:0] wq[$];
   logic [8:0]       dq[$];

   always #5 clk = ~clk;

   gpu_program_loader #(
      .IMEM_DEPTH (DEPTH),
      .INSTR_W    (IW),
      .PIPE_SLACK (SLACK)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .host_valid (host_valid),
      .host_ready (host_ready),
      .host_data  (host_data),
      .host_last  (host_last),
      .imem_we    (imem_we),
      .imem_waddr (imem_waddr),
      .imem_wdata (imem_wdata),
      .core_reset (core_reset),
      .busy       (busy),
      .done       (done),
      .trunc      (trunc)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic unexpected(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: event with nothing expected at %0t", name, $time);
   endtask

   // Monitor: pops expectations whenever the DUT writes or pulses done.
   int   run_len   = 0;
   int   last_run  = 0;
   logic prev_cr   = 1'b1;
   logic prev_done = 1'b0;
   always @(negedge clk) begin
      logic [AW+IW-1:0] ew;
      logic [8:0]       ed;
      if (imem_we === 1'b1) begin
         if (wq.size() == 0) begin
            unexpected("imem_write");
         end else begin
            ew = wq.pop_front();
            check("wr_addr", 32'(imem_waddr), 32'(ew[IW +: AW]));
            check("wr_data", 32'(imem_wdata), 32'(ew[IW-1:0]));
         end
      end
      if (core_reset === 1'b0) begin
         run_len++;
      end else if (prev_cr === 1'b0) begin
         last_run = run_len;
         run_len  = 0;
      end
      prev_cr = core_reset;
      if (done === 1'b1) begin
         check("done_pulse_width", 32'(prev_done), 32'd0);
         if (dq.size() == 0) begin
            unexpected("done_pulse");
         end else begin
            ed = dq.pop_front();
            check("run_window", 32'(last_run), 32'(ed[8:1]));
            check("trunc_at_done", 32'(trunc), 32'(ed[0]));
         end
      end
      prev_done = done;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Returns in the DONE cycle, or flags a timeout.
   task automatic wait_done(input int budget);
      for (int k = 0; k < budget && done !== 1'b1; k++) begin
         tick();
      end
      check("done_seen", 32'(done), 32'd1);
   endtask

   task automatic drive(input logic v, input logic [IW-1:0] d, input logic l);
      host_valid = v;
      host_data  = d;
      host_last  = l;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      drive(1'b0, '0, 1'b0);
      tick();
      tick();
      check("rst_host_ready", 32'(host_ready), 32'd1);
      check("rst_core_reset", 32'(core_reset), 32'd1);
      check("rst_imem_we", 32'(imem_we), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_trunc", 32'(trunc), 32'd0);
      check("rst_waddr", 32'(imem_waddr), 32'd0);
      reset = 1'b0;
      tick();

      // Basic three-word load, valid held high
      drive(1'b1, 16'h4A40, 1'b0); wq.push_back({3'd0, 16'h4A40}); tick();
      drive(1'b1, 16'h6240, 1'b0); wq.push_back({3'd1, 16'h6240}); tick();
      drive(1'b1, 16'h0000, 1'b1); wq.push_back({3'd2, 16'h0000});
      dq.push_back({8'd5, 1'b0}); tick();
      drive(1'b0, '0, 1'b0);
      check("busy_in_run", 32'(busy), 32'd1);
      check("ready_in_run", 32'(host_ready), 32'd0);
      check("core_reset_in_run", 32'(core_reset), 32'd0);
      wait_done(40);
      tick();
      check("ready_after_done", 32'(host_ready), 32'd1);
      check("busy_after_done", 32'(busy), 32'd0);

      // Valid gaps 1,0,1,0,1
      drive(1'b1, 16'h1111, 1'b0); wq.push_back({3'd0, 16'h1111}); tick();
      drive(1'b0, 16'hDEAD, 1'b0); tick();
      drive(1'b1, 16'h2222, 1'b0); wq.push_back({3'd1, 16'h2222}); tick();
      drive(1'b0, 16'hBEEF, 1'b0); tick();
      drive(1'b1, 16'h3333, 1'b1); wq.push_back({3'd2, 16'h3333});
      dq.push_back({8'd5, 1'b0}); tick();
      drive(1'b0, '0, 1'b0);
      wait_done(40);
      tick();

      // Ten words without host_last into an eight-word memory
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, IW'(16'hA000 + i), 1'b0);
         if (i < 8) begin
            wq.push_back({AW'(i), IW'(16'hA000 + i)});
            if (i == 7) dq.push_back({8'd10, 1'b1});
         end else begin
            check("trunc_ready_low", 32'(host_ready), 32'd0);
            check("trunc_no_write", 32'(imem_we), 32'd0);
         end
         tick();
      end
      drive(1'b0, '0, 1'b0);
      check("trunc_set", 32'(trunc), 32'd1);
      wait_done(60);
      tick();
      check("trunc_sticky", 32'(trunc), 32'd1);

      // Single-word program clears trunc on its first beat
      drive(1'b1, 16'h0000, 1'b1); wq.push_back({3'd0, 16'h0000});
      dq.push_back({8'd3, 1'b0}); tick();
      drive(1'b0, '0, 1'b0);
      check("trunc_cleared", 32'(trunc), 32'd0);
      wait_done(40);
      tick();

      // Reset asserted in RUN cycle 2
      drive(1'b1, 16'h5555, 1'b0); wq.push_back({3'd0, 16'h5555}); tick();
      drive(1'b1, 16'h6666, 1'b1); wq.push_back({3'd1, 16'h6666}); tick();
      drive(1'b0, '0, 1'b0);
      tick();
      reset = 1'b1;
      tick();
      check("midrun_core_reset", 32'(core_reset), 32'd1);
      check("midrun_ready", 32'(host_ready), 32'd1);
      check("midrun_busy", 32'(busy), 32'd0);
      check("midrun_done", 32'(done), 32'd0);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("no_done_after_reset", 32'(done), 32'd0);
      end
      drive(1'b1, 16'h7777, 1'b1); wq.push_back({3'd0, 16'h7777});
      dq.push_back({8'd3, 1'b0}); tick();
      drive(1'b0, '0, 1'b0);
      wait_done(40);
      tick();

      // Beat offered during DONE is taken one cycle later at address 0
      drive(1'b1, 16'h1234, 1'b1); wq.push_back({3'd0, 16'h1234});
      dq.push_back({8'd3, 1'b0}); tick();
      drive(1'b0, '0, 1'b0);
      wait_done(40);
      drive(1'b1, 16'h4321, 1'b1);
      check("done_ready_low", 32'(host_ready), 32'd0);
      check("done_no_write", 32'(imem_we), 32'd0);
      wq.push_back({3'd0, 16'h4321});
      dq.push_back({8'd3, 1'b0});
      tick();
      check("load_after_done_ready", 32'(host_ready), 32'd1);
      tick();
      drive(1'b0, '0, 1'b0);
      wait_done(40);
      tick();

      check("writes_drained", 32'(wq.size()), 32'd0);
      check("dones_drained", 32'(dq.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
